// File: rtl/uq_tdd_pkg.sv
// Shared types and constants for the TDD RF front-end sequencer.
// States, force_mode codes, default guard-delay width and small state
// classification helpers used by the sequencer and its bench.
package uq_tdd_pkg;

  // Default width of the guard-delay fields, in clk cycles.
  localparam int DLY_W_DEF = 10;

  // Sequencer states. Guard states are named by direction (D2U = DL to UL)
  // and by phase (_SW = waiting before the switch moves, _EN = waiting
  // before the amplifier is enabled).
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    DL     = 3'd1,
    D2U_SW = 3'd2,
    D2U_EN = 3'd3,
    UL     = 3'd4,
    U2D_SW = 3'd5,
    U2D_EN = 3'd6
  } tdd_state_e;

  // force_mode input codes.
  typedef enum logic [1:0] {
    FORCE_NONE = 2'd0,
    FORCE_DL   = 2'd1,
    FORCE_UL   = 2'd2,
    FORCE_OFF  = 2'd3
  } force_mode_e;

  // True in any state where a guard interval is running.
  function automatic logic is_guard(input tdd_state_e s);
    return (s == D2U_SW) || (s == D2U_EN) || (s == U2D_SW) || (s == U2D_EN);
  endfunction

  // True in the guard states that precede a switch change.
  function automatic logic is_sw_guard(input tdd_state_e s);
    return (s == D2U_SW) || (s == U2D_SW);
  endfunction

  // True in the guard states heading towards UL.
  function automatic logic is_d2u(input tdd_state_e s);
    return (s == D2U_SW) || (s == D2U_EN);
  endfunction

endpackage

// File: rtl/uq_tdd_guard_cnt.sv
// Guard interval counter for the TDD RF sequencer.
// A load pulse clears the count and captures the delay; done is high once
// the count equals the captured delay, so an interval lasts dly+1 cycles.
module uq_tdd_guard_cnt
  import uq_tdd_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             load,
  input  logic [DLY_W-1:0] dly,
  output logic             done
);

  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;

  assign done = (cnt_q == dly_q);

  // Next count: restart on load, otherwise count up and park at the limit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    dly_d = dly_q;
    if (load) begin
      cnt_d = '0;
      dly_d = dly;
    end else if (!done) begin
      cnt_d = cnt_q + DLY_W'(1);
    end
  end

  // Count and captured delay registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!i_rst_n) begin
      cnt_q <= '0;
      dly_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dly_q <= dly_d;
    end
  end

endmodule

// File: rtl/uq_tdd_rf_seq.sv
// TDD RF front-end sequencer: drives the DL power amplifier, the UL LNA and
// the TX/RX RF switch from the TDD pattern, inserting an amplifier-off to
// switch guard and a switch to amplifier-on guard on every direction change.
// Optional build macro UQ_TDD_RF_SEQ_STAT_EN adds a saturating abort_cnt
// output (guard reversals) with synchronous clear input stat_clr.
module uq_tdd_rf_seq
  import uq_tdd_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             tdd_out,
  input  logic             tsync_valid,
  input  logic             gate_on_invalid,
  input  logic [1:0]       force_mode,
  input  logic [DLY_W-1:0] sw_dly,
  input  logic [DLY_W-1:0] en_dly,
`ifdef UQ_TDD_RF_SEQ_STAT_EN
  input  logic             stat_clr,
  output logic [15:0]      abort_cnt,
`endif
  output logic             pa_en,
  output logic             lna_en,
  output logic             rf_sw_tx,
  output logic             seq_busy
);

  tdd_state_e       state_q, state_d;
  logic             tdd_q;
  logic             pa_q, pa_d;
  logic             lna_q, lna_d;
  logic             rf_q, rf_d;
  logic             busy_q, busy_d;
  logic             go_off;
  logic             dl_req;
  logic             cnt_load;
  logic [DLY_W-1:0] cnt_dly;
  logic             cnt_done;

  uq_tdd_guard_cnt #(.DLY_W(DLY_W)) u_guard (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .load    (cnt_load),
    .dly     (cnt_dly),
    .done    (cnt_done)
  );

  // Next state: kill switch first, then direction reversals, then guard expiry.
  always_comb begin
    state_d = state_q;
    go_off  = (force_mode == FORCE_OFF) || (gate_on_invalid && !tsync_valid);
    unique case (force_mode)
      FORCE_DL: dl_req = 1'b1;
      FORCE_UL: dl_req = 1'b0;
      default:  dl_req = tdd_q;
    endcase

    if (go_off) begin
      state_d = OFF;
    end else begin
      unique case (state_q)
        OFF:     state_d = dl_req ? U2D_SW : D2U_SW;
        DL:      if (!dl_req) state_d = D2U_SW;
        // Switch still on TX: only the PA-on guard is needed to go back.
        D2U_SW:  if (dl_req) state_d = U2D_EN;
                 else if (cnt_done) state_d = D2U_EN;
        // Switch already on RX: going back needs a full switch guard.
        D2U_EN:  if (dl_req) state_d = U2D_SW;
                 else if (cnt_done) state_d = UL;
        UL:      if (dl_req) state_d = U2D_SW;
        U2D_SW:  if (!dl_req) state_d = D2U_EN;
                 else if (cnt_done) state_d = U2D_EN;
        U2D_EN:  if (!dl_req) state_d = D2U_SW;
                 else if (cnt_done) state_d = DL;
        default: state_d = OFF;
      endcase
    end

    // Every entry into a guard state restarts the counter with a fresh delay.
    cnt_load = is_guard(state_d) && (state_d != state_q);
    cnt_dly  = is_sw_guard(state_d) ? sw_dly : en_dly;
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    pa_d   = (state_d == DL);
    lna_d  = (state_d == UL);
    busy_d = is_guard(state_d);
    // The switch only moves when a switch guard completes (or on a reversal
    // whose switch position is already correct); it holds during _SW states.
    unique case (state_d)
      OFF:     rf_d = 1'b0;
      DL:      rf_d = 1'b1;
      UL:      rf_d = 1'b0;
      U2D_EN:  rf_d = 1'b1;
      D2U_EN:  rf_d = 1'b0;
      default: rf_d = rf_q;
    endcase
  end

  // State, sampled TDD pattern and output registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= OFF;
      tdd_q   <= 1'b0;
      pa_q    <= 1'b0;
      lna_q   <= 1'b0;
      rf_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tdd_q   <= tdd_out;
      pa_q    <= pa_d;
      lna_q   <= lna_d;
      rf_q    <= rf_d;
      busy_q  <= busy_d;
    end
  end

  assign pa_en    = pa_q;
  assign lna_en   = lna_q;
  assign rf_sw_tx = rf_q;
  assign seq_busy = busy_q;

`ifdef UQ_TDD_RF_SEQ_STAT_EN
  logic        abort_evt;
  logic [15:0] abort_cnt_q, abort_cnt_d;

  // A reversal is a guard-to-guard move that flips the direction.
  assign abort_evt = is_guard(state_q) && is_guard(state_d) &&
                     (is_d2u(state_q) != is_d2u(state_d));

  // Saturating reversal counter with synchronous clear taking priority.
  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (stat_clr) begin
      abort_cnt_d = '0;
    end else if (abort_evt && (abort_cnt_q != 16'hFFFF)) begin
      abort_cnt_d = abort_cnt_q + 16'd1;
    end
  end

  // Reversal counter register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      abort_cnt_q <= '0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_uq_tdd_rf_seq.sv
// Bench for uq_tdd_rf_seq: directed scenarios with hand-computed edge times,
// plus a phase/timer reference model compared on every falling clk edge.
module tb_uq_tdd_rf_seq;

  localparam int DLY_W = 10;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             tdd_out;
  logic             tsync_valid;
  logic             gate_on_invalid;
  logic [1:0]       force_mode;
  logic [DLY_W-1:0] sw_dly;
  logic [DLY_W-1:0] en_dly;
  logic             stat_clr;
  logic             pa_en, lna_en, rf_sw_tx, seq_busy;
`ifdef UQ_TDD_RF_SEQ_STAT_EN
  logic [15:0]      abort_cnt;
`endif

  uq_tdd_rf_seq #(.DLY_W(DLY_W)) dut (
    .clk             (clk),
    .i_rst_n         (i_rst_n),
    .tdd_out         (tdd_out),
    .tsync_valid     (tsync_valid),
    .gate_on_invalid (gate_on_invalid),
    .force_mode      (force_mode),
    .sw_dly          (sw_dly),
    .en_dly          (en_dly),
`ifdef UQ_TDD_RF_SEQ_STAT_EN
    .stat_clr        (stat_clr),
    .abort_cnt       (abort_cnt),
`endif
    .pa_en           (pa_en),
    .lna_en          (lna_en),
    .rf_sw_tx        (rf_sw_tx),
    .seq_busy        (seq_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Sequencer seen as: idle (amps off), settled in a direction, or waiting
  // out the switch / enable guard with a countdown.
  typedef enum {PH_OFF, PH_ON, PH_WSW, PH_WEN} ph_t;
  ph_t m_ph     = PH_OFF;
  bit  m_dir    = 1'b0;   // direction being settled into (1 = DL)
  bit  m_sw     = 1'b0;   // switch position (1 = TX)
  bit  m_tdd    = 1'b0;   // tdd_out as seen one edge late
  int  m_timer  = 0;
  int  m_aborts = 0;

  initial forever begin
    bit goal, kill, rev;
    @(posedge clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_ph = PH_OFF; m_dir = 1'b0; m_sw = 1'b0; m_tdd = 1'b0;
      m_timer = 0; m_aborts = 0;
    end else begin
      goal = (force_mode == 2'd1) ? 1'b1 : (force_mode == 2'd2) ? 1'b0 : m_tdd;
      kill = (force_mode == 2'd3) || (gate_on_invalid && !tsync_valid);
      rev  = 1'b0;
      if (kill) begin
        m_ph = PH_OFF; m_sw = 1'b0;
      end else begin
        case (m_ph)
          PH_OFF: begin m_ph = PH_WSW; m_dir = goal; m_timer = int'(sw_dly); end
          PH_ON: if (goal != m_dir) begin
            m_ph = PH_WSW; m_dir = goal; m_timer = int'(sw_dly);
          end
          PH_WSW: if (goal != m_dir) begin
            m_ph = PH_WEN; m_dir = goal; m_sw = goal; m_timer = int'(en_dly); rev = 1'b1;
          end else if (m_timer == 0) begin
            m_ph = PH_WEN; m_sw = m_dir; m_timer = int'(en_dly);
          end else m_timer--;
          PH_WEN: if (goal != m_dir) begin
            m_ph = PH_WSW; m_dir = goal; m_timer = int'(sw_dly); rev = 1'b1;
          end else if (m_timer == 0) m_ph = PH_ON;
          else m_timer--;
          default: m_ph = PH_OFF;
        endcase
      end
      if (stat_clr) m_aborts = 0;
      else if (rev && m_aborts < 65535) m_aborts++;
      m_tdd = tdd_out;
    end
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    check("pa_en",    pa_en,    (m_ph == PH_ON) &&  m_dir);
    check("lna_en",   lna_en,   (m_ph == PH_ON) && !m_dir);
    check("rf_sw_tx", rf_sw_tx, m_sw);
    check("seq_busy", seq_busy, (m_ph == PH_WSW) || (m_ph == PH_WEN));
    check("pa_lna_exclusive", pa_en & lna_en, 0);
`ifdef UQ_TDD_RF_SEQ_STAT_EN
    check("abort_cnt", abort_cnt, m_aborts);
`endif
  end

  // ---------------- directed helpers ----------------
  function automatic logic dut_sig(input int sel);
    case (sel)
      0:       return pa_en;
      1:       return lna_en;
      2:       return rf_sw_tx;
      default: return seq_busy;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a DUT output to reach val; returns the edge index.
  task automatic wait_sig(input int sel, input logic val, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (dut_sig(sel) == val) begin
        at = cyc;
        return;
      end
    end
    check($sformatf("timeout_sig%0d", sel), 0, 1);
  endtask

  function automatic logic [3:0] outs();
    return {pa_en, lna_en, rf_sw_tx, seq_busy};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t, at, at2;
    bit rf_dropped;
    tdd_out = 1'b1; tsync_valid = 1'b1; gate_on_invalid = 1'b0;
    force_mode = 2'd0; sw_dly = 10'd3; en_dly = 10'd2; stat_clr = 1'b0;
    #1 i_rst_n = 1'b0;
    tick(2);
    check("reset_outputs", outs(), 4'b0000);
`ifdef UQ_TDD_RF_SEQ_STAT_EN
    check("reset_abort_cnt", abort_cnt, 0);
`endif

    // Release: first edge goes OFF->D2U_SW (tdd_q still 0), then reverses.
    i_rst_n = 1'b1;
    t = cyc;
    tick(1);
    check("first_edge_d2u_sw", outs(), 4'b0001);
    wait_sig(0, 1'b1, 50, at);
    check("startup_dl_edge", at, t + 5);

    // Long guards: pa off T+2, switch RX T+103, LNA on T+154.
    sw_dly = 10'd100; en_dly = 10'd50;
    t = cyc; tdd_out = 1'b0;
    wait_sig(0, 1'b0, 10, at);
    check("d2u_pa_fall", at, t + 2);
    wait_sig(2, 1'b0, 200, at);
    check("d2u_rf_fall", at, t + 103);
    wait_sig(1, 1'b1, 200, at);
    check("d2u_lna_rise", at, t + 154);

    // Zero guards: each guard state lasts one cycle.
    sw_dly = 10'd0; en_dly = 10'd0;
    tdd_out = 1'b1;
    wait_sig(0, 1'b1, 20, at);
    tick(3);
    t = cyc; tdd_out = 1'b0;
    wait_sig(0, 1'b0, 10, at);
    check("zero_pa_fall", at, t + 2);
    wait_sig(1, 1'b1, 10, at2);
    check("zero_lna_rise", at2, t + 4);

    // Reversal 40 cycles into D2U_SW.
    sw_dly = 10'd100; en_dly = 10'd20;
    stat_clr = 1'b1; tick(1); stat_clr = 1'b0;
    tdd_out = 1'b1;
    wait_sig(0, 1'b1, 300, at);
    tick(2);
    tdd_out = 1'b0;
    wait_sig(0, 1'b0, 10, at);
    t = at;
    tick(40);
    tdd_out = 1'b1;
    rf_dropped = 1'b0; at2 = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!rf_sw_tx) rf_dropped = 1'b1;
      if (pa_en) begin at2 = cyc; break; end
    end
    check("rev_pa_back_edge", at2, t + 63);
    check("rev_rf_stays_tx", rf_dropped, 1'b0);
`ifdef UQ_TDD_RF_SEQ_STAT_EN
    check("rev_abort_cnt", abort_cnt, 1);
`endif

    // Sync loss in UL with gating, then recovery through full guards.
    sw_dly = 10'd5; en_dly = 10'd7;
    tdd_out = 1'b0;
    wait_sig(1, 1'b1, 80, at);
    gate_on_invalid = 1'b1; tsync_valid = 1'b0;
    tick(1);
    check("gate_off_next_edge", outs(), 4'b0000);
    tick(3);
    check("gate_held_off", outs(), 4'b0000);
    t = cyc; tsync_valid = 1'b1;
    wait_sig(1, 1'b1, 40, at);
    check("gate_recover_lna", at, t + 15);
    gate_on_invalid = 1'b0;

    // Force modes override tdd_q but keep the guards.
    t = cyc; force_mode = 2'd1;
    wait_sig(0, 1'b1, 40, at);
    check("force_dl_pa", at, t + 15);
    force_mode = 2'd3;
    tick(1);
    check("force_off", outs(), 4'b0000);
    tick(2);
    t = cyc; force_mode = 2'd2;
    wait_sig(1, 1'b1, 40, at);
    check("force_ul_lna", at, t + 15);
    force_mode = 2'd0;
    tick(3);

    // Asynchronous reset in the middle of U2D_EN.
    sw_dly = 10'd5; en_dly = 10'd30;
    t = cyc; tdd_out = 1'b1;
    tick(20);
    check("in_u2d_en", outs(), 4'b0011);
    #2 i_rst_n = 1'b0;
    #1 check("async_reset_outs", outs(), 4'b0000);
    @(posedge clk); #1 i_rst_n = 1'b1;
    tick(2);

    // Random TDD pulses with random guards.
    for (int p = 0; p < 40; p++) begin
      sw_dly = 10'($urandom_range(0, 40));
      en_dly = 10'($urandom_range(0, 40));
      tdd_out = ~tdd_out;
      tick($urandom_range(2, 300));
    end
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
